instr_encoder: RTL and testbench
================================

# instr_encoder

Program-loader encoder for the single-cycle MIPS core: it takes one instruction at a time as decoded fields (kind, rs, rt, rd, imm, target) and produces the 32-bit machine word. It then writes that word into the next consecutive instruction-memory slot from the text base upward, holding the write until the memory acknowledges it. It is the inverse of the core's opcode/func decode: testbenches and the boot path use it to place programs in IM. It covers the same instruction set the core executes: addu, subu, ori, sw, lw, beq, lui, jal, jr, nop.

## Interface
- DEPTH, 1024, number of IM words available; the write index runs 0..DEPTH-1.
- BASE, 32'h3000, byte address of IM word 0.

- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low
- in_valid  in  1  request carries an instruction
- out_ready  out  1  encoder accepts a request this cycle
- in_kind  in  4  instruction kind (package constants)
- in_rs / in_rt / in_rd  in  5 each  register fields
- in_imm  in  16  immediate / branch offset
- in_target  in  26  jal target field
- in_IM_ack  in  1  IM has taken the presented write
- out_IM_WE  out  1  write strobe
- out_IM_addr  out  32  byte address of the write
- out_IM_data  out  32  encoded instruction word
- out_count  out  clog2(DEPTH)+1  number of words committed
- out_full  out  1  DEPTH words committed
- out_error  out  1  one-cycle pulse when an illegal kind is accepted

## Operation
- Handshake: a request is accepted on a rising edge where in_valid && out_ready.
- out_ready = 1 only in the IDLE state.
- Field encodings:
  - R-type: {6'b0, rs, rt, rd, 5'b0, func}.
    - ADDU uses func 100001.
    - SUBU uses func 100011.
  - JR: {6'b0, rs, 15'b0, 6'b001000}.
  - NOP: 32'h0.
  - I-type: {op, rs, rt, imm}, with op = ORI 001101, LW 100011, SW 101011, BEQ 000100.
  - LUI: {001111, 5'b0, rt, imm}; rs is ignored.
  - JAL: {000011, target}.
- Fields an instruction kind does not use are forced to zero in the output word, not passed through.
- Kinds 10..15 are illegal:
  - the request is accepted;
  - out_error is high for the following cycle;
  - no write is made and out_count is unchanged.
- States:
  - IDLE:
    - accept a legal request -> WRITE, latching data = encode(fields) and addr = BASE + 4*out_count;
    - accept an illegal request -> stay in IDLE and pulse out_error.
  - WRITE:
    - out_IM_WE = 1, with addr and data held stable;
    - on in_IM_ack, out_count increments, then go to FULL if the new count == DEPTH, else IDLE.
  - FULL:
    - out_full = 1 and out_ready = 0;
    - requests are ignored; only reset leaves this state.
- Write addresses increase by 4 per committed word and never wrap; FULL blocks any further writes.

## Timing
- Reset (reset == 0 at a rising edge):
  - state goes to IDLE;
  - out_count = 0, out_IM_WE = 0, out_IM_addr = BASE, out_IM_data = 0, out_error = 0, out_full = 0;
  - out_ready = 1 from the first cycle after reset is released.
- Reset during WRITE abandons the pending word: out_IM_WE drops on that edge and the count is not incremented.
- Latency:
  - a request accepted at edge k puts out_IM_WE high in cycle k+1;
  - if in_IM_ack is already high in cycle k+1, the word commits at edge k+1 and out_ready returns in cycle k+2.
- Minimum spacing is 2 cycles per instruction; out_ready is low throughout WRITE.
- in_IM_ack is sampled only in WRITE; an ack in IDLE or FULL is ignored.
- out_count and out_full update on the same edge as the commit.
- out_error is registered and asserted for exactly one cycle.

## Structure
- Shared package `mips_isa_pkg`:
  - KIND_* constants: ADDU=0, SUBU=1, ORI=2, SW=3, LW=4, BEQ=5, LUI=6, JAL=7, JR=8, NOP=9;
  - OP_* and FUNC_* 6-bit constants;
  - TEXT_BASE;
  - state encoding.
- The same package supplies the constants the core's decoder compares against.
- One combinational sub-module, `instr_pack`, maps (kind, fields) to {word, illegal}. The top level holds the FSM, the counter and the output registers.

## Test plan
- ADDU rs=1 rt=2 rd=3, in_IM_ack tied high -> cycle k+1: WE=1, addr=0x3000, data=0x00221821; out_count becomes 1.
- ORI rt=1 imm=0x1234, followed by LUI rt=8 imm=0xFFFF with rs=5 -> data 0x34011234 at 0x3000, then 0x3C08FFFF at 0x3004 (rs dropped).
- JAL target=0x0C00, JR rs=31, BEQ rs=1 rt=2 imm=0xFFFF, NOP -> data 0x0C000C00, 0x03E00008, 0x1022FFFF, 0x00000000 at consecutive addresses.
- kind=12 -> out_error high for one cycle, out_IM_WE stays 0, out_count unchanged, out_ready stays 1.
- in_IM_ack held low for 5 cycles, then assert reset -> WE, addr and data stable for all 5 cycles; after reset, count=0 and the next write goes to 0x3000.
- DEPTH=4: commit 4 words -> out_full=1 and out_ready=0, a fifth request produces no WE, and reset clears out_full.

Source files
------------

// File: rtl/mips_isa_pkg.sv
// mips_isa_pkg
// Shared ISA constants for the single-cycle MIPS core and its program
// loader: instruction-kind codes used by the encoder request interface,
// primary opcodes, R-type function codes, the text-segment base address
// and the encoder FSM state type.
package mips_isa_pkg;

    // Instruction kinds accepted by instr_encoder; codes 10..15 are illegal.
    localparam logic [3:0] KIND_ADDU = 4'd0;
    localparam logic [3:0] KIND_SUBU = 4'd1;
    localparam logic [3:0] KIND_ORI  = 4'd2;
    localparam logic [3:0] KIND_SW   = 4'd3;
    localparam logic [3:0] KIND_LW   = 4'd4;
    localparam logic [3:0] KIND_BEQ  = 4'd5;
    localparam logic [3:0] KIND_LUI  = 4'd6;
    localparam logic [3:0] KIND_JAL  = 4'd7;
    localparam logic [3:0] KIND_JR   = 4'd8;
    localparam logic [3:0] KIND_NOP  = 4'd9;

    // Primary opcodes (instr[31:26]).
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_JAL     = 6'b000011;

    // Function codes for OP_SPECIAL (instr[5:0]).
    localparam logic [5:0] FUNC_ADDU = 6'b100001;
    localparam logic [5:0] FUNC_SUBU = 6'b100011;
    localparam logic [5:0] FUNC_JR   = 6'b001000;

    // Byte address of instruction-memory word 0.
    localparam logic [31:0] TEXT_BASE = 32'h0000_3000;

    // Loader FSM states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_FULL  = 2'd2
    } enc_state_e;

endpackage

// File: rtl/instr_pack.sv
// instr_pack
// Combinational field packer: maps an instruction kind plus its decoded
// fields to the 32-bit MIPS machine word. Fields a kind does not use are
// dropped (zero in the word), never passed through.
//   kind_i    instruction kind (KIND_* codes)
//   rs_i/rt_i/rd_i  register fields
//   imm_i     16-bit immediate / branch offset
//   target_i  26-bit jump target
//   word_o    packed instruction word (zero for illegal kinds)
//   illegal_o kind is outside the supported set
module instr_pack
    import mips_isa_pkg::*;
(
    input  logic [3:0]  kind_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [15:0] imm_i,
    input  logic [25:0] target_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);

    always_comb begin
        word_o    = '0;
        illegal_o = 1'b0;
        case (kind_i)
            KIND_ADDU: word_o = {OP_SPECIAL, rs_i, rt_i, rd_i, 5'b0, FUNC_ADDU};
            KIND_SUBU: word_o = {OP_SPECIAL, rs_i, rt_i, rd_i, 5'b0, FUNC_SUBU};
            KIND_ORI:  word_o = {OP_ORI, rs_i, rt_i, imm_i};
            KIND_SW:   word_o = {OP_SW,  rs_i, rt_i, imm_i};
            KIND_LW:   word_o = {OP_LW,  rs_i, rt_i, imm_i};
            KIND_BEQ:  word_o = {OP_BEQ, rs_i, rt_i, imm_i};
            KIND_LUI:  word_o = {OP_LUI, 5'b0, rt_i, imm_i};
            KIND_JAL:  word_o = {OP_JAL, target_i};
            KIND_JR:   word_o = {OP_SPECIAL, rs_i, 15'b0, FUNC_JR};
            KIND_NOP:  word_o = '0;
            default:   illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder
// Program loader: accepts one instruction per request as decoded fields,
// encodes it and writes the word into consecutive IM slots from BASE
// upward, holding each write until IM acknowledges it. Stops in FULL
// once DEPTH words are committed; only reset leaves FULL.
//   clk, reset          clock, synchronous active-low reset
//   in_valid/out_ready  request handshake (ready only in IDLE)
//   in_kind, in_rs, in_rt, in_rd, in_imm, in_target  instruction fields
//   in_IM_ack           IM has taken the presented write
//   out_IM_WE/addr/data IM write port, stable while WE is high
//   out_count           committed word count
//   out_full            DEPTH words committed
//   out_error           one-cycle pulse after an illegal kind is accepted
module instr_encoder
    import mips_isa_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter logic [31:0] BASE  = TEXT_BASE
)
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       out_ready,
    input  logic [3:0]                 in_kind,
    input  logic [4:0]                 in_rs,
    input  logic [4:0]                 in_rt,
    input  logic [4:0]                 in_rd,
    input  logic [15:0]                in_imm,
    input  logic [25:0]                in_target,
    input  logic                       in_IM_ack,
    output logic                       out_IM_WE,
    output logic [31:0]                out_IM_addr,
    output logic [31:0]                out_IM_data,
    output logic [$clog2(DEPTH):0]     out_count,
    output logic                       out_full,
    output logic                       out_error
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    enc_state_e    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic          err_q, err_d;

    logic [31:0]   pack_word;
    logic          pack_illegal;

    instr_pack u_pack (
        .kind_i    (in_kind),
        .rs_i      (in_rs),
        .rt_i      (in_rt),
        .rd_i      (in_rd),
        .imm_i     (in_imm),
        .target_i  (in_target),
        .word_o    (pack_word),
        .illegal_o (pack_illegal)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (pack_illegal) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_WRITE;
                        data_d  = pack_word;
                        addr_d  = BASE + (32'(count_q) << 2);
                    end
                end
            end
            S_WRITE: begin
                if (in_IM_ack) begin
                    count_d = count_q + 1'b1;
                    // Compare the pre-increment count so the check stays in CW bits.
                    state_d = (count_q == CW'(DEPTH - 1)) ? S_FULL : S_IDLE;
                end
            end
            S_FULL: begin
                state_d = S_FULL;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            addr_q  <= BASE;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign out_ready   = (state_q == S_IDLE);
    assign out_IM_WE   = (state_q == S_WRITE);
    assign out_full    = (state_q == S_FULL);
    assign out_IM_addr = addr_q;
    assign out_IM_data = data_q;
    assign out_count   = count_q;
    assign out_error   = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder
// Directed self-checking bench for instr_encoder: reset values, every
// legal kind with hand-encoded words, illegal kinds, a stalled write
// abandoned by reset, and the FULL condition on a DEPTH=4 instance.
module tb_instr_encoder;
    import mips_isa_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [3:0]  in_kind;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        in_IM_ack;

    logic        out_ready, out_IM_WE, out_full, out_error;
    logic [31:0] out_IM_addr, out_IM_data;
    logic [10:0] out_count;

    logic        reset4, valid4, ack4;
    logic        ready4, we4, full4, err4;
    logic [31:0] addr4, data4;
    logic [2:0]  count4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(1024), .BASE(32'h0000_3000)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .out_ready(out_ready),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_imm(in_imm), .in_target(in_target), .in_IM_ack(in_IM_ack),
        .out_IM_WE(out_IM_WE), .out_IM_addr(out_IM_addr), .out_IM_data(out_IM_data),
        .out_count(out_count), .out_full(out_full), .out_error(out_error)
    );

    instr_encoder #(.DEPTH(4), .BASE(32'h0000_3000)) dut4 (
        .clk(clk), .reset(reset4), .in_valid(valid4), .out_ready(ready4),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_imm(in_imm), .in_target(in_target), .in_IM_ack(ack4),
        .out_IM_WE(we4), .out_IM_addr(addr4), .out_IM_data(data4),
        .out_count(count4), .out_full(full4), .out_error(err4)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with the main DUT in IDLE.
    task automatic do_reset();
        reset    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge with in_IM_ack high: issue one request, check the
    // write cycle, then check the commit.
    task automatic send_commit(input string tag, input logic [3:0] kind,
                               input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                               input logic [15:0] imm, input logic [25:0] tgt,
                               input logic [31:0] exp_addr, input logic [31:0] exp_data,
                               input logic [31:0] exp_count);
        in_kind = kind; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_target = tgt;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq({tag, ".we"},    32'(out_IM_WE),  32'd1);
        check_eq({tag, ".addr"},  out_IM_addr,     exp_addr);
        check_eq({tag, ".data"},  out_IM_data,     exp_data);
        check_eq({tag, ".rdy0"},  32'(out_ready),  32'd0);
        @(posedge clk);
        @(negedge clk);
        check_eq({tag, ".count"}, 32'(out_count),  exp_count);
        check_eq({tag, ".rdy1"},  32'(out_ready),  32'd1);
        check_eq({tag, ".we0"},   32'(out_IM_WE),  32'd0);
    endtask

    initial begin
        logic [3:0]  bad_kinds [3];
        logic [31:0] c;
        bad_kinds[0] = 4'd10; bad_kinds[1] = 4'd12; bad_kinds[2] = 4'd15;

        reset = 1'b0; in_valid = 1'b0; in_IM_ack = 1'b0;
        in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_target = '0;
        reset4 = 1'b0; valid4 = 1'b0; ack4 = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst.count", 32'(out_count),  32'd0);
        check_eq("rst.we",    32'(out_IM_WE),  32'd0);
        check_eq("rst.addr",  out_IM_addr,     32'h3000);
        check_eq("rst.data",  out_IM_data,     32'h0);
        check_eq("rst.err",   32'(out_error),  32'd0);
        check_eq("rst.full",  32'(out_full),   32'd0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst.ready", 32'(out_ready),  32'd1);

        // ADDU with ack tied high
        in_IM_ack = 1'b1;
        send_commit("addu", KIND_ADDU, 5'd1, 5'd2, 5'd3, 16'hABCD, 26'h3FF_FFFF,
                    32'h3000, 32'h0022_1821, 32'd1);

        // ORI then LUI (rs dropped); then the rest of the set, with junk in unused fields
        do_reset();
        send_commit("ori",  KIND_ORI,  5'd0,  5'd1, 5'd17, 16'h1234, 26'h155_5555,
                    32'h3000, 32'h3401_1234, 32'd1);
        send_commit("lui",  KIND_LUI,  5'd5,  5'd8, 5'd9,  16'hFFFF, 26'h0AA_AAAA,
                    32'h3004, 32'h3C08_FFFF, 32'd2);
        send_commit("jal",  KIND_JAL,  5'd7,  5'd9, 5'd11, 16'h5555, 26'h000_0C00,
                    32'h3008, 32'h0C00_0C00, 32'd3);
        send_commit("jr",   KIND_JR,   5'd31, 5'd4, 5'd6,  16'hFFFF, 26'h3FF_FFFF,
                    32'h300C, 32'h03E0_0008, 32'd4);
        send_commit("beq",  KIND_BEQ,  5'd1,  5'd2, 5'd31, 16'hFFFF, 26'h123_4567,
                    32'h3010, 32'h1022_FFFF, 32'd5);
        send_commit("nop",  KIND_NOP,  5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FF_FFFF,
                    32'h3014, 32'h0000_0000, 32'd6);
        send_commit("subu", KIND_SUBU, 5'd4,  5'd5, 5'd6,  16'hFFFF, 26'h3FF_FFFF,
                    32'h3018, 32'h0085_3023, 32'd7);
        send_commit("sw",   KIND_SW,   5'd29, 5'd8, 5'd3,  16'h0010, 26'h3FF_FFFF,
                    32'h301C, 32'hAFA8_0010, 32'd8);
        send_commit("lw",   KIND_LW,   5'd29, 5'd9, 5'd3,  16'hFFFC, 26'h3FF_FFFF,
                    32'h3020, 32'h8FA9_FFFC, 32'd9);

        // Illegal kinds: accepted, error pulse, no write
        for (int i = 0; i < 3; i++) begin
            c = 32'(out_count);
            check_eq("ill.ready", 32'(out_ready), 32'd1);
            in_kind  = bad_kinds[i];
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            check_eq("ill.err1",  32'(out_error), 32'd1);
            check_eq("ill.we",    32'(out_IM_WE), 32'd0);
            check_eq("ill.count", 32'(out_count), c);
            check_eq("ill.rdy",   32'(out_ready), 32'd1);
            @(posedge clk);
            @(negedge clk);
            check_eq("ill.err0",  32'(out_error), 32'd0);
            check_eq("ill.we2",   32'(out_IM_WE), 32'd0);
        end
        send_commit("post_ill", KIND_ADDU, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0,
                    32'h3024, 32'h0022_1821, 32'd10);

        // Stalled write, then reset abandons it
        do_reset();
        in_IM_ack = 1'b0;
        in_kind = KIND_ORI; in_rs = 5'd0; in_rt = 5'd3; in_imm = 16'h0005;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_eq("stall.we",    32'(out_IM_WE), 32'd1);
            check_eq("stall.addr",  out_IM_addr,    32'h3000);
            check_eq("stall.data",  out_IM_data,    32'h3403_0005);
            check_eq("stall.rdy",   32'(out_ready), 32'd0);
            check_eq("stall.count", 32'(out_count), 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("abort.we",    32'(out_IM_WE), 32'd0);
        check_eq("abort.count", 32'(out_count), 32'd0);
        reset     = 1'b1;
        in_IM_ack = 1'b1;   // ack while IDLE must be ignored
        @(posedge clk);
        @(negedge clk);
        check_eq("idleack.count", 32'(out_count), 32'd0);
        check_eq("idleack.rdy",   32'(out_ready), 32'd1);
        send_commit("after_abort", KIND_ADDU, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0,
                    32'h3000, 32'h0022_1821, 32'd1);

        // DEPTH=4 instance: fill, then a rejected fifth request, then reset
        reset4 = 1'b1;
        ack4   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("d4.ready", 32'(ready4), 32'd1);
        in_kind = KIND_ADDU; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd3;
        for (int i = 0; i < 4; i++) begin
            valid4 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            valid4 = 1'b0;
            check_eq("d4.we",   32'(we4), 32'd1);
            check_eq("d4.addr", addr4,    32'h3000 + 32'(i) * 32'd4);
            @(posedge clk);
            @(negedge clk);
            check_eq("d4.count", 32'(count4), 32'(i + 1));
            check_eq("d4.full",  32'(full4),  (i == 3) ? 32'd1 : 32'd0);
        end
        check_eq("d4.rdy_full", 32'(ready4), 32'd0);
        valid4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("d4.no_we1", 32'(we4), 32'd0);
        @(posedge clk);
        @(negedge clk);
        valid4 = 1'b0;
        check_eq("d4.no_we2",  32'(we4),    32'd0);
        check_eq("d4.count_h", 32'(count4), 32'd4);
        check_eq("d4.full_h",  32'(full4),  32'd1);
        reset4 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("d4.rst_full",  32'(full4),  32'd0);
        check_eq("d4.rst_count", 32'(count4), 32'd0);
        reset4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("d4.rst_rdy", 32'(ready4), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
